three_input_rr_arbiter: RTL and testbench
=========================================

Name: three_input_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among three requesters a, b and c.
- The downstream resource is the OR-combined output path of the three-input gate.
- Issues a registered one-hot grant and holds it while the owner keeps requesting.
- Forces rotation after HOLD_MAX consecutive grant cycles if another requester is waiting, so no requester starves.

Parameters:
- HOLD_MAX, default 4: maximum consecutive cycles one owner may hold the grant while others wait. Legal range is 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low, asynchronous.
- req  input  3  request vector: bit0 = a, bit1 = b, bit2 = c. Level-sensitive.
- gnt  output  3  one-hot grant, registered. All zeros when idle.
- gnt_id  output  2  index of the current owner (0..2). 2'd3 when idle.
- out  output  1  OR of gnt bits, registered (resource busy).
- preempt  output  1  one-cycle pulse, asserted in the first cycle of a grant produced by forced rotation.

Behaviour:
- Reset (async assert, sync release). Outputs: gnt=3'b000, gnt_id=2'd3, out=0, preempt=0. State: IDLE, last=2, cnt=0. Because last=2, requester 0 has top priority first.
- Arbitration order: from pointer p, search p+1, p+2, p (mod 3). The first set bit wins.
- Pointer update: last takes the index of every newly granted owner.
- States: IDLE and GRANT. All outputs are registered from the next state.
- Grant latency: req rising in IDLE produces gnt on the next rising edge, one cycle.
- IDLE, no req: stay in IDLE.
- IDLE, any req: GRANT winner w; cnt=1; preempt=0.
- GRANT owner o, req[o]=0 (release), other reqs pending: grant winner searched from o+1 on the next edge. No idle bubble; cnt=1; preempt=0.
- GRANT owner o, req[o]=0, no req pending: go to IDLE; gnt=0, out=0, gnt_id=3.
- GRANT owner o, req[o]=1, cnt<HOLD_MAX: keep o; cnt=cnt+1.
- GRANT owner o, req[o]=1, cnt==HOLD_MAX, another req pending: rotate to the winner among the others, searched from o+1; cnt=1; preempt=1 for that one cycle.
- GRANT owner o, req[o]=1, cnt==HOLD_MAX, no other req: keep o; cnt saturates at HOLD_MAX. A later-arriving requester takes over on the next edge after it asserts; preempt=1 for that takeover.
- Simultaneous requests: resolved purely by the rotating order; ties cannot occur.
- Invariants:
  - gnt is always one-hot or zero.
  - out equals the OR of gnt.
  - gnt_id is consistent with gnt.
- cnt width: 4 bits, sufficient for HOLD_MAX up to 15.
- Reset asserted mid-grant: all outputs clear immediately without waiting for clk; the pointer returns to 2.

Decomposition:
- Shared package three_gate_pkg holds:
  - state encoding constants ST_IDLE and ST_GRANT;
  - NUM_REQ=3;
  - IDLE_ID=2'd3.
- One sub-module, rr_pick3: purely combinational. Inputs are req[2:0], pointer[1:0] and an exclude mask. Outputs are winner index and a found flag. It is used for both the fresh-grant and rotation searches.
- The FSM, counter and pointer stay in the top module.

Test Plan:
- Reset and first grant:
  - Hold rst_n=0 with req=3'b111: outputs stay 0/3/0/0.
  - Release reset: next edge gives gnt=3'b001, gnt_id=0, out=1.
- Release handoff:
  - From owner 0 with req=3'b110, drop bit0: next edge gives gnt=3'b010 with no zero cycle.
  - Drop all reqs: next edge gives gnt=0, gnt_id=3, out=0.
- Forced rotation with HOLD_MAX=4 and req=3'b111 held:
  - Owner 0 holds for 4 cycles, then 1 for 4 cycles, then 2 for 4 cycles, then 0 again.
  - preempt pulses 1 cycle at each handoff.
- Saturation:
  - Only req=3'b100 for 10 cycles: gnt=3'b100 throughout, preempt=0.
  - Then assert bit0: next edge gives gnt=3'b001, preempt=1.
- Round-robin fairness:
  - Alternate single-cycle requests 3'b011 then release.
  - Grants alternate 0,1,0,1 as the pointer advances; neither requester is ever skipped.
- Async reset mid-grant:
  - Pulse rst_n low for 2 ns between edges while gnt=3'b010.
  - gnt=0 immediately; the first grant after release is to requester 0.

Source files
------------

// File: rtl/three_gate_pkg.sv
// Shared constants and helpers for the three-requester round-robin arbiter.
package three_gate_pkg;

  localparam int NUM_REQ = 3;
  localparam logic [1:0] IDLE_ID = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    if (idx < 2'd3) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotating-priority search over three requests, starting after ptr.
module rr_pick3
  import three_gate_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] excl,
  output logic [1:0] winner,
  output logic       found
);

  logic [2:0] masked;
  logic [2:0] cand;
  logic [1:0] order [NUM_REQ];

  assign masked = req & ~excl;

  // order[0] is ptr+1, order[1] is ptr+2, order[2] is ptr itself (all mod 3)
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_order
      logic [2:0] sum;
      assign sum          = {1'b0, ptr} + 3'(gi + 1);
      assign order[gi]    = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      assign cand[gi]     = (order[gi] < 2'd3) && masked[order[gi]];
    end
  endgenerate

  always_comb begin
    winner = IDLE_ID;
    found  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = order[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/three_input_rr_arbiter.sv
// Round-robin arbiter for three requesters with bounded hold time and
// registered one-hot grant outputs.
module three_input_rr_arbiter
  import three_gate_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       out,
  output logic       preempt
);

  logic [0:0] state_reg, state_next;
  logic [1:0] last_reg, last_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [2:0] gnt_reg, gnt_next;
  logic [1:0] gnt_id_reg, gnt_id_next;
  logic       out_reg, out_next;
  logic       preempt_reg, preempt_next;

  logic [1:0] win;
  logic       found;
  logic [2:0] excl;
  logic       owner_req;

  // While granted, the owner is excluded so a forced rotation never re-picks it;
  // on release req[owner] is already 0, so the mask changes nothing there.
  assign excl      = (state_reg == ST_GRANT) ? onehot3(last_reg) : 3'b000;
  assign owner_req = (last_reg < 2'd3) && req[last_reg];

  rr_pick3 u_pick (
    .req    (req),
    .ptr    (last_reg),
    .excl   (excl),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    preempt_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          state_next = ST_GRANT;
          last_next  = win;
          cnt_next   = 4'd1;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          if (found) begin
            last_next = win;
            cnt_next  = 4'd1;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
          end
        end else if (cnt_reg < 4'(HOLD_MAX)) begin
          cnt_next = cnt_reg + 4'd1;
        end else if (found) begin
          last_next    = win;
          cnt_next     = 4'd1;
          preempt_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    gnt_next    = (state_next == ST_GRANT) ? onehot3(last_next) : 3'b000;
    gnt_id_next = (state_next == ST_GRANT) ? last_next : IDLE_ID;
    out_next    = (state_next == ST_GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      last_reg    <= 2'd2;
      cnt_reg     <= 4'd0;
      gnt_reg     <= 3'b000;
      gnt_id_reg  <= IDLE_ID;
      out_reg     <= 1'b0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      out_reg     <= out_next;
      preempt_reg <= preempt_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign out     = out_reg;
  assign preempt = preempt_reg;

endmodule

// File: tb/tb_three_input_rr_arbiter.sv
// Directed testbench for three_input_rr_arbiter with HOLD_MAX=4.
module tb_three_input_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       out;
  logic       preempt;

  int applied;
  int miscompares;

  three_input_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .out     (out),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic chk_all(input string tag, input logic [2:0] eg, input logic ep);
    chk({tag, ".gnt"}, {1'b0, gnt}, {1'b0, eg});
    chk({tag, ".gnt_id"}, {2'b00, gnt_id}, {2'b00, id_of(eg)});
    chk({tag, ".out"}, {3'b000, out}, {3'b000, (eg != 3'b000)});
    chk({tag, ".preempt"}, {3'b000, preempt}, {3'b000, ep});
    $display("step %-12s req=%b gnt=%b id=%0d out=%b preempt=%b", tag, req, gnt, gnt_id, out, preempt);
  endtask

  initial begin
    logic [1:0] owner;
    logic [2:0] eg;
    applied     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = 3'b111;

    // Reset held with all requests active
    tick();
    tick();
    tick();
    chk_all("reset", 3'b000, 1'b0);

    rst_n = 1'b1;
    tick();
    chk_all("first_gnt", 3'b001, 1'b0);

    // Release handoff from owner 0 straight to owner 1
    req = 3'b110;
    tick();
    chk_all("handoff", 3'b010, 1'b0);

    req = 3'b000;
    tick();
    chk_all("to_idle", 3'b000, 1'b0);

    // Forced rotation: owner 0 first, then all three request continuously
    req = 3'b001;
    tick();
    chk_all("rot_k0", 3'b001, 1'b0);
    req = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      owner = 2'((k / 4) % 3);
      eg    = 3'b001 << owner;
      chk_all($sformatf("rot_k%0d", k), eg, (k % 4) == 0);
    end

    // Saturation: only c requests for 10 cycles
    req = 3'b100;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all($sformatf("sat_%0d", k), 3'b100, 1'b0);
    end
    req = 3'b101;
    tick();
    chk_all("sat_takeover", 3'b001, 1'b1);

    // Park pointer on 2 so the fairness run starts with requester 0
    req = 3'b000;
    tick();
    chk_all("idle_a", 3'b000, 1'b0);
    req = 3'b100;
    tick();
    chk_all("park_c", 3'b100, 1'b0);
    req = 3'b000;
    tick();
    chk_all("idle_b", 3'b000, 1'b0);

    for (int k = 0; k < 4; k++) begin
      req = 3'b011;
      tick();
      chk_all($sformatf("fair_g%0d", k), (k % 2 == 0) ? 3'b001 : 3'b010, 1'b0);
      req = 3'b000;
      tick();
      chk_all($sformatf("fair_i%0d", k), 3'b000, 1'b0);
    end

    // Async reset pulse between clock edges while owner 1 holds
    req = 3'b010;
    tick();
    chk_all("pre_async", 3'b010, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'b000, 1'b0);
    #1;
    rst_n = 1'b1;
    req   = 3'b111;
    tick();
    chk_all("post_async", 3'b001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
